// File: rtl/fproc_meas_if.sv
// fproc_meas_if: core-side function-processor request/response bundle.
//   fproc_id     per-core function ID, slice c = [c*FPROC_ID_WIDTH +: FPROC_ID_WIDTH]
//   fproc_enable per-core one-cycle request strobe
//   fproc_ready  per-core one-cycle response strobe
//   fproc_data   per-core result, slice c = [c*DATA_WIDTH +: DATA_WIDTH]
// master: the cores (drive requests); slave: the responder.
interface fproc_meas_if #(
   parameter int unsigned N_CORES        = 8,
   parameter int unsigned FPROC_ID_WIDTH = 8,
   parameter int unsigned DATA_WIDTH     = 32
);
   logic [N_CORES*FPROC_ID_WIDTH-1:0] fproc_id;
   logic [N_CORES-1:0]                fproc_enable;
   logic [N_CORES-1:0]                fproc_ready;
   logic [N_CORES*DATA_WIDTH-1:0]     fproc_data;

   modport master (
      output fproc_id,
      output fproc_enable,
      input  fproc_ready,
      input  fproc_data
   );

   modport slave (
      input  fproc_id,
      input  fproc_enable,
      output fproc_ready,
      output fproc_data
   );
endinterface

// File: rtl/fproc_meas.sv
// fproc_meas: answers per-core fproc requests with measurement results.
// A measurement-ID request is served once the requesting core has a measurement on that
// channel it has not consumed yet (or one arrives that cycle); out-of-range IDs return 0.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   fproc       slave side of the core request/response bundle (all outputs registered)
//   meas        measurement bit per channel
//   meas_valid  per-channel strobe qualifying meas
module fproc_meas #(
   parameter int unsigned N_CORES        = 8,
   parameter int unsigned N_MEAS         = 8,
   parameter int unsigned FPROC_ID_WIDTH = 8,
   parameter int unsigned DATA_WIDTH     = 32
) (
   input  logic               clk,
   input  logic               reset,
   fproc_meas_if.slave        fproc,
   input  logic [N_MEAS-1:0]  meas,
   input  logic [N_MEAS-1:0]  meas_valid
);

   typedef enum logic {StIdle, StWait} state_t;

   state_t                    state_q [N_CORES];
   state_t                    state_d [N_CORES];
   logic [FPROC_ID_WIDTH-1:0] id_q    [N_CORES];
   logic [FPROC_ID_WIDTH-1:0] id_d    [N_CORES];
   logic [N_MEAS-1:0]         fresh_q [N_CORES];
   logic [N_MEAS-1:0]         fresh_d [N_CORES];
   logic [FPROC_ID_WIDTH-1:0] eff_id  [N_CORES];
   logic [N_MEAS-1:0]         hit     [N_CORES];

   logic [N_MEAS-1:0]             last_q, newest;
   logic [N_CORES-1:0]            ready_q, ready_d, evaluate, serve;
   logic [N_CORES*DATA_WIDTH-1:0] data_q, data_d;

   // Newest value per channel: a same-cycle measurement bypasses the stored one.
   assign newest = (meas_valid & meas) | (~meas_valid & last_q);

   always_comb begin
      ready_d  = '0;
      data_d   = data_q;
      evaluate = '0;
      serve    = '0;
      for (int c = 0; c < N_CORES; c++) begin
         state_d[c] = state_q[c];
         id_d[c]    = id_q[c];
         fresh_d[c] = fresh_q[c] | meas_valid;
         eff_id[c]  = (state_q[c] == StWait) ? id_q[c]
                                             : fproc.fproc_id[c*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
         hit[c] = '0;
         for (int i = 0; i < N_MEAS; i++) begin
            hit[c][i] = (32'(eff_id[c]) == 32'(i));
         end

         // An empty hit vector means the ID is out of range and is served at once.
         unique case (state_q[c])
            StIdle: begin
               evaluate[c] = fproc.fproc_enable[c];
               if (fproc.fproc_enable[c]) begin
                  id_d[c] = eff_id[c];
               end
            end
            StWait: evaluate[c] = 1'b1;
         endcase

         serve[c] = evaluate[c] & (~(|hit[c]) | (|(hit[c] & (fresh_q[c] | meas_valid))));

         if (evaluate[c]) begin
            state_d[c] = serve[c] ? StIdle : StWait;
         end

         if (serve[c]) begin
            ready_d[c] = 1'b1;
            data_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(|(hit[c] & newest));
            // Consumption wins over a same-cycle arrival: that value went out via the bypass.
            fresh_d[c] = fresh_d[c] & ~hit[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < N_CORES; c++) begin
            state_q[c] <= StIdle;
            id_q[c]    <= '0;
            fresh_q[c] <= '0;
         end
         last_q  <= '0;
         ready_q <= '0;
         data_q  <= '0;
      end else begin
         for (int c = 0; c < N_CORES; c++) begin
            state_q[c] <= state_d[c];
            id_q[c]    <= id_d[c];
            fresh_q[c] <= fresh_d[c];
         end
         last_q  <= newest;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign fproc.fproc_ready = ready_q;
   assign fproc.fproc_data  = data_q;

endmodule

// File: tb/tb_fproc_meas.sv
// tb_fproc_meas: self-checking bench for fproc_meas.
// A behavioural model tracks every core each cycle; a vector table and hand sequences add
// fixed expectations for the corner cases, followed by randomized traffic.
module tb_fproc_meas;
   localparam int NC = 8;
   localparam int NM = 8;
   localparam int W  = 8;
   localparam int D  = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [NM-1:0] meas, meas_valid;

   fproc_meas_if #(.N_CORES(NC), .FPROC_ID_WIDTH(W), .DATA_WIDTH(D)) bus ();

   fproc_meas #(
      .N_CORES(NC), .N_MEAS(NM), .FPROC_ID_WIDTH(W), .DATA_WIDTH(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .fproc(bus),
      .meas(meas),
      .meas_valid(meas_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   bit [NM-1:0] m_last;
   bit [NM-1:0] m_fresh [NC];
   bit          m_pend  [NC];
   int          m_pid   [NC];
   bit          m_rdy   [NC];
   logic [31:0] m_data  [NC];

   typedef struct {
      logic [7:0]  mv;
      logic [7:0]  m;
      int          core;
      logic        en;
      logic [7:0]  id;
      logic        rdy;
      logic [31:0] data;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dout(input int c);
      return bus.fproc_data[c*D +: D];
   endfunction

   function automatic logic [31:0] rdy(input int c);
      return 32'(bus.fproc_ready[c]);
   endfunction

   task automatic req(input int c, input int id);
      bus.fproc_enable[c]      = 1'b1;
      bus.fproc_id[c*W +: W]   = W'(id);
   endtask

   // Apply the rules to the inputs present before the coming edge.
   task automatic ref_step();
      bit          srv [NC];
      int          sid [NC];
      logic [31:0] sd  [NC];
      if (reset) begin
         m_last = '0;
         for (int c = 0; c < NC; c++) begin
            m_fresh[c] = '0; m_pend[c] = 0; m_pid[c] = 0; m_rdy[c] = 0; m_data[c] = '0;
         end
         return;
      end
      for (int c = 0; c < NC; c++) begin
         srv[c] = 0;
         sd[c]  = '0;
         sid[c] = -1;
         if (m_pend[c]) sid[c] = m_pid[c];
         else if (bus.fproc_enable[c]) sid[c] = int'(bus.fproc_id[c*W +: W]);
         if (sid[c] >= NM) begin
            srv[c] = 1;
         end else if (sid[c] >= 0 && (m_fresh[c][sid[c]] || meas_valid[sid[c]])) begin
            srv[c] = 1;
            sd[c]  = {31'b0, meas_valid[sid[c]] ? meas[sid[c]] : m_last[sid[c]]};
         end
      end
      for (int c = 0; c < NC; c++) begin
         m_rdy[c] = srv[c];
         if (srv[c]) m_data[c] = sd[c];
         if (sid[c] >= 0) begin
            m_pend[c] = !srv[c];
            m_pid[c]  = sid[c];
         end
         for (int i = 0; i < NM; i++) begin
            if (srv[c] && sid[c] == i) m_fresh[c][i] = 0;
            else if (meas_valid[i]) m_fresh[c][i] = 1;
         end
      end
      for (int i = 0; i < NM; i++) begin
         if (meas_valid[i]) m_last[i] = meas[i];
      end
   endtask

   // One clock: model, edge, compare all cores, then return inputs to idle.
   task automatic cycle();
      ref_step();
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("model_ready[%0d]", c), rdy(c), 32'(m_rdy[c]));
         chk($sformatf("model_data[%0d]", c), dout(c), m_data[c]);
      end
      reset            = 1'b0;
      meas             = '0;
      meas_valid       = '0;
      bus.fproc_enable = '0;
      bus.fproc_id     = '0;
   endtask

   initial begin
      reset            = 1'b1;
      meas             = '0;
      meas_valid       = '0;
      bus.fproc_enable = '0;
      bus.fproc_id     = '0;
      cycle();
      chk("reset_ready", 32'(bus.fproc_ready), 32'd0);
      for (int c = 0; c < NC; c++) chk($sformatf("reset_data[%0d]", c), dout(c), 32'd0);

      // mv, m, core, en, id, expected ready, expected data (of that core after the edge)
      vecs[0]  = '{mv:8'h05, m:8'h05, core:0, en:1'b0, id:8'd0,   rdy:1'b0, data:32'd0};
      vecs[1]  = '{mv:8'h00, m:8'h00, core:0, en:1'b1, id:8'd2,   rdy:1'b1, data:32'd1};
      vecs[2]  = '{mv:8'h00, m:8'h00, core:0, en:1'b1, id:8'd2,   rdy:1'b0, data:32'd1};
      vecs[3]  = '{mv:8'h00, m:8'h00, core:0, en:1'b0, id:8'd0,   rdy:1'b0, data:32'd1};
      vecs[4]  = '{mv:8'h04, m:8'h00, core:0, en:1'b0, id:8'd0,   rdy:1'b1, data:32'd0};
      vecs[5]  = '{mv:8'h00, m:8'h00, core:0, en:1'b1, id:8'd2,   rdy:1'b0, data:32'd0};
      vecs[6]  = '{mv:8'h04, m:8'h04, core:0, en:1'b0, id:8'd0,   rdy:1'b1, data:32'd1};
      vecs[7]  = '{mv:8'h01, m:8'h00, core:1, en:1'b1, id:8'd0,   rdy:1'b1, data:32'd0};
      vecs[8]  = '{mv:8'h00, m:8'h00, core:0, en:1'b1, id:8'd200, rdy:1'b1, data:32'd0};
      vecs[9]  = '{mv:8'h20, m:8'h20, core:3, en:1'b0, id:8'd0,   rdy:1'b0, data:32'd0};
      vecs[10] = '{mv:8'h20, m:8'h00, core:3, en:1'b0, id:8'd0,   rdy:1'b0, data:32'd0};
      vecs[11] = '{mv:8'h00, m:8'h00, core:3, en:1'b1, id:8'd5,   rdy:1'b1, data:32'd0};
      vecs[12] = '{mv:8'h00, m:8'h00, core:3, en:1'b1, id:8'd5,   rdy:1'b0, data:32'd0};
      vecs[13] = '{mv:8'h00, m:8'h00, core:3, en:1'b1, id:8'd9,   rdy:1'b0, data:32'd0};
      vecs[14] = '{mv:8'h00, m:8'h00, core:4, en:1'b1, id:8'd2,   rdy:1'b1, data:32'd1};
      vecs[15] = '{mv:8'h00, m:8'h00, core:4, en:1'b0, id:8'd0,   rdy:1'b0, data:32'd1};

      for (int k = 0; k < 16; k++) begin
         meas_valid = vecs[k].mv;
         meas       = vecs[k].m;
         if (vecs[k].en) req(vecs[k].core, int'(vecs[k].id));
         cycle();
         chk($sformatf("vec%0d_ready", k), rdy(vecs[k].core), 32'(vecs[k].rdy));
         chk($sformatf("vec%0d_data", k), dout(vecs[k].core), vecs[k].data);
      end

      // Reset while waiting drops the request and any same-cycle measurement.
      reset = 1'b1;
      cycle();
      req(2, 3);
      cycle();
      chk("rst_wait_ready", rdy(2), 32'd0);
      repeat (3) begin
         cycle();
         chk("rst_wait_hold", rdy(2), 32'd0);
      end
      reset = 1'b1; meas_valid = 8'h08; meas = 8'h08;
      cycle();
      chk("rst_cycle_ready", rdy(2), 32'd0);
      req(5, 3);
      cycle();
      chk("rst_meas_discarded", rdy(5), 32'd0);
      meas_valid = 8'h08; meas = 8'h08;
      cycle();
      chk("rst_dropped_req", rdy(2), 32'd0);
      chk("post_rst_serve_ready", rdy(5), 32'd1);
      chk("post_rst_serve_data", dout(5), 32'd1);
      req(2, 200);
      cycle();
      chk("oor_ready", rdy(2), 32'd1);
      chk("oor_data", dout(2), 32'd0);

      // Several cores consume the same measurement independently.
      reset = 1'b1;
      cycle();
      meas_valid = 8'h10; meas = 8'h10;
      cycle();
      cycle();
      req(0, 4); req(1, 4);
      cycle();
      chk("multi_c0_ready", rdy(0), 32'd1);
      chk("multi_c1_ready", rdy(1), 32'd1);
      chk("multi_c0_data", dout(0), 32'd1);
      chk("multi_c1_data", dout(1), 32'd1);
      repeat (14) cycle();
      req(7, 4);
      cycle();
      chk("multi_c7_ready", rdy(7), 32'd1);
      chk("multi_c7_data", dout(7), 32'd1);
      req(2, 4);
      cycle();
      chk("multi_c2_fresh", rdy(2), 32'd1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 99) == 0);
         meas_valid = NM'($urandom & $urandom);
         meas       = NM'($urandom);
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 3) == 0)
               req(c, ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, NM - 1)));
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fproc_meas.md
# fproc_meas

Function-processor responder that sits between the qubit measurement readout and the distributed-processor cores. It completes the core-side fproc handshake: a core pulses a request with a function ID, waits, and receives a ready pulse with a 32-bit result. For measurement IDs, the result is delivered only once a measurement has arrived that the requesting core has not yet consumed. Each core has its own independent request channel.

## Interface
- `N_CORES`, default 8: number of processor cores served.
- `N_MEAS`, default 8: number of measurement channels.
- `FPROC_ID_WIDTH`, default 8: width of a function ID.
- `DATA_WIDTH`, default 32: width of the result returned to a core.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `fproc_id`  in  N_CORES*FPROC_ID_WIDTH  per-core function ID; slice c is bits [c*W +: W].
- `fproc_enable`  in  N_CORES  per-core one-cycle request strobe (the core's fproc_out_ready).
- `fproc_ready`  out  N_CORES  per-core one-cycle response strobe.
- `fproc_data`  out  N_CORES*DATA_WIDTH  per-core result; slice c is bits [c*DATA_WIDTH +: DATA_WIDTH].
- `meas`  in  N_MEAS  measurement bit per channel.
- `meas_valid`  in  N_MEAS  per-channel strobe; `meas[i]` is valid in that cycle.

## Operation
- **Per-channel storage:** `last[i]` (1 bit) is written with `meas[i]` on every `meas_valid[i]`.
- **Per-core, per-channel freshness:** `fresh[c][i]` means core c has not yet consumed the latest measurement on channel i.
- **Per-core FSM with two states:**
  - IDLE: on `fproc_enable[c]`, latch `id_q[c] <= fproc_id[c]`.
  - WAIT: pending request.
- **Serve condition for core c with ID `id`:**
  - `id >= N_MEAS`: immediate serve, data 0.
  - Otherwise: `fresh[c][id] | meas_valid[id]`.
- **Evaluation point:** the serve condition is evaluated in the IDLE cycle where `fproc_enable[c]` is high, using the live `fproc_id`. It is also evaluated in every WAIT cycle, using `id_q`.
- **On serve:**
  - `fproc_ready[c] <= 1` for one cycle.
  - `fproc_data[c] <= zero-extend(meas_valid[id] ? meas[id] : last[id])`. The bypass always returns the newest value.
  - `fresh[c][id] <= 0`.
  - FSM goes to / stays in IDLE.
- **Not served:** IDLE→WAIT (if enabled) or remain in WAIT.
- **Freshness update per (c,i), serve-clear taking priority:**
  - If core c is served on channel i this cycle: `fresh <= 0`. This holds even if `meas_valid[i]` is high the same cycle, because that value is consumed via the bypass.
  - Else if `meas_valid[i]`: `fresh <= 1`.
- **Repeated measurements:** a second `meas_valid[i]` before consumption overwrites `last[i]` and leaves `fresh` at 1. Only the newest value is returned; no queueing.
- **`fproc_enable` while in WAIT:** ignored. The core contract is one outstanding request per core.
- **Concurrency:** cores are fully independent; any number may be served in the same cycle, including from the same channel.

## Timing
- **Reset values:**
  - `fproc_ready = 0`, `fproc_data = 0`.
  - All FSMs IDLE, all `fresh = 0`, `last = 0`, `id_q = 0`.
- **All outputs registered.** `fproc_data[c]` holds its value until the next serve for core c. The core may sample it during the ready cycle or any later cycle.
- **Enable at cycle T with serve condition true:** `fproc_ready` high in T+1.
- **Enable at T with condition false, first `meas_valid[id]` at cycle V > T:** `fproc_ready` high in V+1, data = `meas[id]` of cycle V.
- **Reset mid-WAIT:** request dropped, no ready pulse is generated, and all freshness is cleared. A measurement arriving in the reset cycle is discarded.
- **Out-of-range ID:** ready in T+1, data 0, no freshness change.

## Test plan
- **Fresh hit:** `meas_valid[2]=1, meas[2]=1` at cycle 5; core 0 enables with id=2 at cycle 10 -> `fproc_ready[0]` at 11, data 0x00000001; a second id=2 request at 15 waits (no ready through cycle 30).
- **Wait then bypass:** core 3 enables id=1 at cycle 4; `meas_valid[1]=1, meas[1]=1` at cycle 9 -> ready only at 10, data 1; `fresh[3][1]` stays 0 (next request waits).
- **Same-cycle arrival with enable:** core 1 enables id=0 at cycle 6 with `meas_valid[0]=1, meas[0]=0` and a stale fresh 1 stored -> ready at 7, data 0.
- **Multi-core:** measurement on channel 4 at cycle 3; cores 0, 1 and 7 request id=4 at cycles 5, 5 and 20 -> all three served with the same value, the first two in cycle 6 and core 7 in cycle 21; core 2 never requested, so its freshness for channel 4 stays 1.
- **Overwrite:** `meas[5]` = 1 at cycle 2, then 0 at cycle 4; core 0 requests id=5 at 8 -> data 0; next request waits.
- **Reset and out-of-range:** core 2 in WAIT on id=3; reset at cycle 12 -> no ready; measurement on channel 3 at 14 -> no ready; core 2 requests id=200 at 20 -> ready at 21, data 0.
